row_collect_stage: RTL and testbench

- Parametrised successor of the MAC-array output stage: gathers per-lane MAC results into complete output rows and writes them to output memory.
- Adds LANES/DW/AW/DEPTH generalisation, multi-row jobs with auto-incrementing destination address, a DEPTH-row skid FIFO, OMEM_Ready backpressure, and sticky error flags.
- Sits between the MAC array outputs and the output SRAM write port; the controller starts a job with START_CALC and waits for Job_Done.

---
 rtl/row_collect_stage.sv | 212 +++++++++++++++++++++
 tb/tb_row_collect_stage.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_collect_stage.sv
// row_collect_stage: gathers per-lane MAC results into complete output rows
// and writes them, in completion order, to the output memory. Rows are held
// in an output register backed by a DEPTH-entry skid FIFO under OMEM_Ready
// backpressure. A START_CALC pulse begins (or aborts and restarts) a job of
// ROWS rows at destination ODST, and sticky flags report dropped rows and
// lanes that were re-validated before their row completed.
module row_collect_stage #(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START_CALC,
    input  logic [AW-1:0]       ODST,
    input  logic [AW-1:0]       ROWS,
    input  logic [LANES*DW-1:0] MAC_ODATA,
    input  logic [LANES-1:0]    MAC_OVALID,
    input  logic                OMEM_Ready,
    output logic [LANES*DW-1:0] OMEM_Data,
    output logic [AW-1:0]       OMEM_Addr,
    output logic                OMEM_Write,
    output logic                Row_Done,
    output logic                Job_Done,
    output logic                Busy,
    output logic                Overflow,
    output logic                Lane_Dup
);

    localparam int RW = LANES * DW;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // Collection state
    logic [LANES-1:0] mask_q, mask_d;
    logic [RW-1:0]    lane_q, lane_d;
    logic [AW-1:0]    cidx_q, issued_q;

    // Job state
    logic [AW-1:0]    odst_q, rows_q, acc_q;
    logic             busy_q, row_done_q, job_done_q, overflow_q, dup_q;

    // Output register and skid FIFO
    logic             out_valid_q;
    logic [RW-1:0]    out_data_q;
    logic [AW-1:0]    out_addr_q;
    logic [RW-1:0]    fifo_data_q [DEPTH];
    logic [AW-1:0]    fifo_addr_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;

    // Per-cycle decisions
    logic [LANES-1:0] mask_base, mask_all;
    logic             row_complete, lane_dup, in_job, accept;
    logic             fifo_empty, fifo_full, out_free;
    logic             load_out, push, pop, drop;
    logic [AW-1:0]    row_addr, acc_inc;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Merge this cycle's valid lanes over the buffered lanes; the result is
    // both the new lane buffer and the row written when the mask completes.
    always_comb begin
        // NOTE: default assignment first so partially-valid cycles never infer a latch.
        lane_d = lane_q;
        for (int i = 0; i < LANES; i++) begin
            if (MAC_OVALID[i]) begin
                lane_d[(LANES-i)*DW-1 -: DW] = MAC_ODATA[(LANES-i)*DW-1 -: DW];
            end
        end
    end

    // A START_CALC cycle behaves as if mask, FIFO and output register were
    // already empty, so same-cycle valids belong to the new job.
    assign mask_base    = START_CALC ? '0 : mask_q;
    assign mask_all     = mask_base | MAC_OVALID;
    assign row_complete = &mask_all;
    assign mask_d       = row_complete ? '0 : mask_all;
    assign lane_dup     = |(mask_base & MAC_OVALID);
    assign row_addr     = START_CALC ? ODST : (odst_q + cidx_q);
    assign in_job       = START_CALC ? (ROWS != '0) : (busy_q && (issued_q != rows_q));

    assign accept       = out_valid_q & OMEM_Ready & ~START_CALC;
    assign fifo_empty   = START_CALC | (count_q == '0);
    assign fifo_full    = ~START_CALC & (count_q == FULL_CNT);
    assign out_free     = START_CALC | ~out_valid_q | accept;
    assign load_out     = row_complete & in_job & out_free & fifo_empty;
    assign push         = row_complete & in_job & ~load_out & (~fifo_full | accept);
    assign drop         = row_complete & fifo_full & ~accept;
    assign pop          = accept & ~fifo_empty;
    assign acc_inc      = acc_q + 1'b1;

    // Lane mask, lane buffer, completion/issue counters and sticky flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mask_q     <= '0;
            lane_q     <= '0;
            cidx_q     <= '0;
            issued_q   <= '0;
            overflow_q <= 1'b0;
            dup_q      <= 1'b0;
        end else begin
            mask_q <= mask_d;
            lane_q <= lane_d;
            if (START_CALC) begin
                cidx_q     <= AW'(row_complete);
                issued_q   <= AW'(row_complete & in_job);
                overflow_q <= 1'b0;
                dup_q      <= 1'b0;
            end else begin
                if (row_complete)
                    cidx_q <= cidx_q + 1'b1;
                if (row_complete && in_job)
                    issued_q <= issued_q + 1'b1;
                overflow_q <= overflow_q | drop;
                dup_q      <= dup_q | lane_dup;
            end
        end
    end

    // Job bookkeeping: accepted-row count, Busy, Row_Done and Job_Done pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            odst_q     <= '0;
            rows_q     <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            row_done_q <= 1'b0;
            job_done_q <= 1'b0;
        end else if (START_CALC) begin
            odst_q     <= ODST;
            rows_q     <= ROWS;
            acc_q      <= '0;
            busy_q     <= (ROWS != '0);
            row_done_q <= 1'b0;
            job_done_q <= (ROWS == '0);
        end else begin
            row_done_q <= accept;
            job_done_q <= 1'b0;
            if (accept) begin
                acc_q <= acc_inc;
                if (busy_q && (acc_inc == rows_q)) begin
                    job_done_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            end
        end
    end

    // Skid FIFO holding completed rows behind the output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is cleared as well so no stale row survives reset;
            // with a large DEPTH this would be left unreset and rely on count_q.
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
        end else if (START_CALC) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= lane_d;
                fifo_addr_q[wr_ptr_q] <= row_addr;
                wr_ptr_q              <= next_ptr(wr_ptr_q);
            end
            if (pop)
                rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Output register: refills from the FIFO head on accept, else takes a
    // freshly completed row, else drops OMEM_Write once accepted or flushed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= fifo_data_q[rd_ptr_q];
            out_addr_q  <= fifo_addr_q[rd_ptr_q];
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_data_q  <= lane_d;
            out_addr_q  <= row_addr;
        end else if (accept || START_CALC) begin
            out_valid_q <= 1'b0;
        end
    end

    assign OMEM_Write = out_valid_q;
    assign OMEM_Data  = out_data_q;
    assign OMEM_Addr  = out_addr_q;
    assign Row_Done   = row_done_q;
    assign Job_Done   = job_done_q;
    assign Busy       = busy_q;
    assign Overflow   = overflow_q;
    assign Lane_Dup   = dup_q;

endmodule

// File: tb/tb_row_collect_stage.sv
// Testbench for row_collect_stage: directed scenarios with random lane data,
// then a randomized run checked every cycle against a row-level model that
// tracks rows in flight as a queue with capacity 1+DEPTH.
module tb_row_collect_stage;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int RW    = LANES * DW;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START_CALC;
    logic [AW-1:0]    ODST, ROWS;
    logic [RW-1:0]    MAC_ODATA;
    logic [LANES-1:0] MAC_OVALID;
    logic             OMEM_Ready;
    logic [RW-1:0]    OMEM_Data;
    logic [AW-1:0]    OMEM_Addr;
    logic             OMEM_Write, Row_Done, Job_Done, Busy, Overflow, Lane_Dup;

    int errors = 0;
    int checks = 0;

    row_collect_stage #(.LANES(LANES), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .START_CALC(START_CALC), .ODST(ODST), .ROWS(ROWS),
        .MAC_ODATA(MAC_ODATA), .MAC_OVALID(MAC_OVALID), .OMEM_Ready(OMEM_Ready),
        .OMEM_Data(OMEM_Data), .OMEM_Addr(OMEM_Addr), .OMEM_Write(OMEM_Write),
        .Row_Done(Row_Done), .Job_Done(Job_Done), .Busy(Busy),
        .Overflow(Overflow), .Lane_Dup(Lane_Dup)
    );

    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [DW-1:0] get_lane(input logic [RW-1:0] v, input int i);
        return v[(LANES-i)*DW-1 -: DW];
    endfunction

    function automatic logic [RW-1:0] set_lane(input logic [RW-1:0] v, input int i,
                                               input logic [DW-1:0] x);
        logic [RW-1:0] r;
        r = v;
        r[(LANES-i)*DW-1 -: DW] = x;
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r = set_lane(r, i, DW'($urandom));
        return r;
    endfunction

    // ---------------- row-level reference model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } row_t;

    row_t             m_q[$];
    logic [DW-1:0]    m_lane [LANES];
    logic [LANES-1:0] m_mask;
    logic [AW-1:0]    m_odst, m_rows, m_cidx, m_issued, m_acc;
    bit               m_busy, m_row_done, m_job_done, m_ovf, m_dup;

    // Advance the model across one clock edge given that cycle's inputs.
    task automatic model_step(input bit start, input logic [AW-1:0] odst,
                              input logic [AW-1:0] rows, input logic [RW-1:0] data,
                              input logic [LANES-1:0] valid, input bit ready);
        bit   acc;
        bit   in_job;
        row_t r;
        if (start) begin
            m_q.delete();
            m_mask = '0; m_cidx = '0; m_issued = '0; m_acc = '0;
            m_odst = odst; m_rows = rows; m_ovf = 0; m_dup = 0;
            m_busy = (rows != 0); m_job_done = (rows == 0); m_row_done = 0;
        end else begin
            acc = (m_q.size() > 0) && ready;
            m_row_done = acc;
            m_job_done = 0;
            if (acc) begin
                void'(m_q.pop_front());
                m_acc = m_acc + 1'b1;
                if (m_busy && m_acc == m_rows) begin
                    m_job_done = 1;
                    m_busy     = 0;
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (valid[i]) begin
                if (m_mask[i]) m_dup = 1;
                m_lane[i] = get_lane(data, i);
                m_mask[i] = 1'b1;
            end
        end
        if (&m_mask) begin
            m_mask = '0;
            r.addr = m_odst + m_cidx;
            r.data = '0;
            for (int i = 0; i < LANES; i++) r.data = set_lane(r.data, i, m_lane[i]);
            m_cidx = m_cidx + 1'b1;
            in_job = m_busy && (m_issued != m_rows);
            if (in_job) m_issued = m_issued + 1'b1;
            if (m_q.size() == 1 + DEPTH) m_ovf = 1;
            else if (in_job) m_q.push_back(r);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({OMEM_Write, OMEM_Addr, OMEM_Data, Row_Done, Job_Done, Busy, Overflow, Lane_Dup} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got W=%b A=%0h D=%0h RD=%b JD=%b B=%b O=%b L=%b, expected all 0",
                     OMEM_Write, OMEM_Addr, OMEM_Data, Row_Done, Job_Done, Busy, Overflow, Lane_Dup);
        end
        RST = 1'b0;
        tick();
        checks++;
        if ({OMEM_Write, Busy, Job_Done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got W/B/JD=%b expected 000", {OMEM_Write, Busy, Job_Done});
        end
    endtask

    task automatic test_single_row();
        logic [LANES-1:0] vl [3] = '{4'b0001, 4'b0100, 4'b1010};
        logic [RW-1:0]    d, exp_row;
        exp_row = '0;
        OMEM_Ready = 1'b1;
        START_CALC = 1'b1; ODST = 4'd3; ROWS = 4'd1;
        tick();
        START_CALC = 1'b0;
        checks++;
        if ({Busy, OMEM_Write, Job_Done} !== 3'b100) begin
            errors++;
            $display("FAIL single_start: got B/W/JD=%b expected 100", {Busy, OMEM_Write, Job_Done});
        end
        for (int k = 0; k < 3; k++) begin
            d = rand_row();
            MAC_ODATA = d; MAC_OVALID = vl[k];
            for (int i = 0; i < LANES; i++)
                if (vl[k][i]) exp_row = set_lane(exp_row, i, get_lane(d, i));
            tick();
            if (k < 2) begin
                checks++;
                if (OMEM_Write !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early_write: got %b expected 0 after valid %0d", OMEM_Write, k);
                end
            end
        end
        MAC_OVALID = '0;
        checks++;
        if ({OMEM_Write, OMEM_Addr, Row_Done, Job_Done, Busy} !== {1'b1, 4'd3, 3'b001}) begin
            errors++;
            $display("FAIL single_write: got W=%b A=%0d RD/JD/B=%b expected W=1 A=3 RD/JD/B=001",
                     OMEM_Write, OMEM_Addr, {Row_Done, Job_Done, Busy});
        end
        checks++;
        if (OMEM_Data !== exp_row) begin
            errors++;
            $display("FAIL single_data: got %h expected %h", OMEM_Data, exp_row);
        end
        tick();
        checks++;
        if ({OMEM_Write, Row_Done, Job_Done, Busy} !== 4'b0110) begin
            errors++;
            $display("FAIL single_done: got W/RD/JD/B=%b expected 0110", {OMEM_Write, Row_Done, Job_Done, Busy});
        end
        tick();
        checks++;
        if ({Row_Done, Job_Done} !== 2'b00) begin
            errors++;
            $display("FAIL single_pulse_width: got RD/JD=%b expected 00", {Row_Done, Job_Done});
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] d [3];
        logic [AW-1:0] exp_addr [3] = '{4'd14, 4'd15, 4'd0};
        OMEM_Ready = 1'b1;
        START_CALC = 1'b1; ODST = 4'd14; ROWS = 4'd3;
        tick();
        START_CALC = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d[k] = rand_row();
            MAC_ODATA = d[k]; MAC_OVALID = '1;
            tick();
            checks++;
            if ({OMEM_Write, OMEM_Addr, OMEM_Data} !== {1'b1, exp_addr[k], d[k]}) begin
                errors++;
                $display("FAIL b2b_write%0d: got W=%b A=%0d D=%h expected W=1 A=%0d D=%h",
                         k, OMEM_Write, OMEM_Addr, OMEM_Data, exp_addr[k], d[k]);
            end
            checks++;
            if ({Row_Done, Job_Done} !== {(k > 0), 1'b0}) begin
                errors++;
                $display("FAIL b2b_pulse%0d: got RD/JD=%b expected %b0", k, {Row_Done, Job_Done}, (k > 0));
            end
        end
        MAC_OVALID = '0;
        tick();
        checks++;
        if ({OMEM_Write, Row_Done, Job_Done, Busy} !== 4'b0110) begin
            errors++;
            $display("FAIL b2b_done: got W/RD/JD/B=%b expected 0110", {OMEM_Write, Row_Done, Job_Done, Busy});
        end
    endtask

    task automatic test_overflow();
        logic [RW-1:0] d [4];
        OMEM_Ready = 1'b0;
        START_CALC = 1'b1; ODST = 4'd8; ROWS = 4'd4;
        tick();
        START_CALC = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d[k] = rand_row();
            MAC_ODATA = d[k]; MAC_OVALID = '1;
            tick();
        end
        MAC_OVALID = '0;
        checks++;
        if ({OMEM_Write, Overflow, Busy} !== 3'b111) begin
            errors++;
            $display("FAIL ovf_flag: got W/O/B=%b expected 111", {OMEM_Write, Overflow, Busy});
        end
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if ({OMEM_Write, OMEM_Addr, OMEM_Data} !== {1'b1, 4'd8, d[0]}) begin
                errors++;
                $display("FAIL ovf_stall%0d: got W=%b A=%0d D=%h expected W=1 A=8 D=%h",
                         s, OMEM_Write, OMEM_Addr, OMEM_Data, d[0]);
            end
        end
        OMEM_Ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            checks++;
            if ({OMEM_Write, OMEM_Addr, OMEM_Data, Row_Done} !== {1'b1, 4'(8 + k), d[k], 1'b1}) begin
                errors++;
                $display("FAIL ovf_drain%0d: got W=%b A=%0d D=%h RD=%b expected W=1 A=%0d D=%h RD=1",
                         k, OMEM_Write, OMEM_Addr, OMEM_Data, Row_Done, 8 + k, d[k]);
            end
        end
        tick();
        checks++;
        if ({OMEM_Write, Row_Done, Job_Done} !== 3'b010) begin
            errors++;
            $display("FAIL ovf_last: got W/RD/JD=%b expected 010", {OMEM_Write, Row_Done, Job_Done});
        end
        tick();
        checks++;
        if ({OMEM_Write, Row_Done, Job_Done, Busy} !== 4'b0001) begin
            errors++;
            $display("FAIL ovf_no_job_done: got W/RD/JD/B=%b expected 0001", {OMEM_Write, Row_Done, Job_Done, Busy});
        end
    endtask

    task automatic test_lane_dup();
        logic [RW-1:0] d, exp_row;
        OMEM_Ready = 1'b1;
        START_CALC = 1'b1; ODST = 4'd2; ROWS = 4'd1;
        tick();
        START_CALC = 1'b0;
        checks++;
        if ({Overflow, Lane_Dup, Busy} !== 3'b001) begin
            errors++;
            $display("FAIL dup_start_clear: got O/L/B=%b expected 001", {Overflow, Lane_Dup, Busy});
        end
        MAC_ODATA = set_lane(rand_row(), 2, 16'hAAAA); MAC_OVALID = 4'b0100;
        tick();
        checks++;
        if (Lane_Dup !== 1'b0) begin
            errors++;
            $display("FAIL dup_first: got %b expected 0", Lane_Dup);
        end
        MAC_ODATA = set_lane(rand_row(), 2, 16'hBBBB); MAC_OVALID = 4'b0100;
        tick();
        checks++;
        if (Lane_Dup !== 1'b1) begin
            errors++;
            $display("FAIL dup_second: got %b expected 1", Lane_Dup);
        end
        d = rand_row();
        MAC_ODATA = d; MAC_OVALID = 4'b1011;
        exp_row = set_lane(d, 2, 16'hBBBB);
        tick();
        MAC_OVALID = '0;
        checks++;
        if ({OMEM_Write, OMEM_Addr, OMEM_Data} !== {1'b1, 4'd2, exp_row}) begin
            errors++;
            $display("FAIL dup_write: got W=%b A=%0d D=%h expected W=1 A=2 D=%h",
                     OMEM_Write, OMEM_Addr, OMEM_Data, exp_row);
        end
        tick();
        checks++;
        if ({Row_Done, Job_Done, Lane_Dup} !== 3'b111) begin
            errors++;
            $display("FAIL dup_sticky: got RD/JD/L=%b expected 111", {Row_Done, Job_Done, Lane_Dup});
        end
        START_CALC = 1'b1; ROWS = 4'd0;
        tick();
        START_CALC = 1'b0;
        checks++;
        if ({Job_Done, Busy, Lane_Dup} !== 3'b100) begin
            errors++;
            $display("FAIL empty_job: got JD/B/L=%b expected 100", {Job_Done, Busy, Lane_Dup});
        end
        tick();
        checks++;
        if ({Job_Done, Busy} !== 2'b00) begin
            errors++;
            $display("FAIL empty_job_pulse: got JD/B=%b expected 00", {Job_Done, Busy});
        end
    endtask

    task automatic test_abort();
        logic [RW-1:0] d;
        OMEM_Ready = 1'b0;
        START_CALC = 1'b1; ODST = 4'd9; ROWS = 4'd2;
        tick();
        START_CALC = 1'b0;
        MAC_ODATA = rand_row(); MAC_OVALID = 4'b0001;
        tick();
        MAC_ODATA = rand_row(); MAC_OVALID = 4'b0001;
        tick();
        MAC_ODATA = rand_row(); MAC_OVALID = 4'b1110;
        tick();
        MAC_OVALID = '0;
        checks++;
        if ({OMEM_Write, OMEM_Addr, Lane_Dup} !== {1'b1, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL abort_stalled: got W=%b A=%0d L=%b expected W=1 A=9 L=1",
                     OMEM_Write, OMEM_Addr, Lane_Dup);
        end
        START_CALC = 1'b1; ODST = 4'd5; ROWS = 4'd1;
        tick();
        START_CALC = 1'b0;
        checks++;
        if ({OMEM_Write, Lane_Dup, Overflow, Busy} !== 4'b0001) begin
            errors++;
            $display("FAIL abort_flush: got W/L/O/B=%b expected 0001", {OMEM_Write, Lane_Dup, Overflow, Busy});
        end
        OMEM_Ready = 1'b1;
        d = rand_row();
        MAC_ODATA = d; MAC_OVALID = '1;
        tick();
        MAC_OVALID = '0;
        checks++;
        if ({OMEM_Write, OMEM_Addr, OMEM_Data} !== {1'b1, 4'd5, d}) begin
            errors++;
            $display("FAIL abort_new_row: got W=%b A=%0d D=%h expected W=1 A=5 D=%h",
                     OMEM_Write, OMEM_Addr, OMEM_Data, d);
        end
        tick();
        checks++;
        if ({Row_Done, Job_Done, Busy} !== 3'b110) begin
            errors++;
            $display("FAIL abort_done: got RD/JD/B=%b expected 110", {Row_Done, Job_Done, Busy});
        end
    endtask

    task automatic test_reset_mid();
        OMEM_Ready = 1'b0;
        START_CALC = 1'b1; ODST = 4'd1; ROWS = 4'd2;
        tick();
        START_CALC = 1'b0;
        MAC_ODATA = rand_row(); MAC_OVALID = '1;
        tick();
        MAC_ODATA = rand_row(); MAC_OVALID = 4'b0011;
        tick();
        MAC_OVALID = '0;
        checks++;
        if (OMEM_Write !== 1'b1) begin
            errors++;
            $display("FAIL rst_pending: got W=%b expected 1", OMEM_Write);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({OMEM_Write, OMEM_Addr, OMEM_Data, Row_Done, Job_Done, Busy, Overflow, Lane_Dup} !== '0) begin
            errors++;
            $display("FAIL rst_async: got W=%b A=%0h D=%0h RD=%b JD=%b B=%b O=%b L=%b, expected all 0",
                     OMEM_Write, OMEM_Addr, OMEM_Data, Row_Done, Job_Done, Busy, Overflow, Lane_Dup);
        end
        @(negedge CLK);
        RST = 1'b0;
        // Re-validating the lanes that were pending before reset must not
        // look like a duplicate: the old partial mask is gone.
        MAC_ODATA = rand_row(); MAC_OVALID = 4'b0011;
        tick();
        checks++;
        if ({Lane_Dup, OMEM_Write} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mask_cleared: got L/W=%b expected 00", {Lane_Dup, OMEM_Write});
        end
        MAC_OVALID = '0;
    endtask

    task automatic test_random();
        bit               st, rdy;
        logic [AW-1:0]    od, rw;
        logic [RW-1:0]    d;
        logic [LANES-1:0] v;
        for (int c = 0; c < 600; c++) begin
            st  = (c == 0) || ($urandom_range(0, 99) < 3);
            od  = AW'($urandom);
            rw  = AW'($urandom_range(0, 6));
            d   = rand_row();
            rdy = ($urandom_range(0, 99) < 60);
            for (int i = 0; i < LANES; i++) v[i] = ($urandom_range(0, 99) < 45);
            START_CALC = st; ODST = od; ROWS = rw;
            MAC_ODATA = d; MAC_OVALID = v; OMEM_Ready = rdy;
            model_step(st, od, rw, d, v, rdy);
            tick();
            checks++;
            if (OMEM_Write !== (m_q.size() > 0)) begin
                errors++;
                $display("FAIL rand_write c=%0d: got %b expected %b", c, OMEM_Write, (m_q.size() > 0));
            end else if (OMEM_Write) begin
                checks++;
                if ({OMEM_Addr, OMEM_Data} !== {m_q[0].addr, m_q[0].data}) begin
                    errors++;
                    $display("FAIL rand_row c=%0d: got A=%0d D=%h expected A=%0d D=%h",
                             c, OMEM_Addr, OMEM_Data, m_q[0].addr, m_q[0].data);
                end
            end
            checks++;
            if ({Row_Done, Job_Done, Busy, Overflow, Lane_Dup} !==
                {m_row_done, m_job_done, m_busy, m_ovf, m_dup}) begin
                errors++;
                $display("FAIL rand_status c=%0d: got RD/JD/B/O/L=%b expected %b", c,
                         {Row_Done, Job_Done, Busy, Overflow, Lane_Dup},
                         {m_row_done, m_job_done, m_busy, m_ovf, m_dup});
            end
        end
        START_CALC = 1'b0;
        MAC_OVALID = '0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; START_CALC = 1'b0; ODST = '0; ROWS = '0;
        MAC_ODATA = '0; MAC_OVALID = '0; OMEM_Ready = 1'b0;
        test_reset();
        test_single_row();
        test_back_to_back();
        test_overflow();
        test_lane_dup();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
